// File: rtl/dbg_pkg.sv
// dbg_pkg: shared definitions for the debug halt controller.
//   dbg_state_e  - controller state, also exported on the debug state output
//   CAUSE_*      - halt_cause encodings
//   DBG_PC_REG   - register index that host accesses may not touch
//   sat_inc16    - saturating increment used by the halted-cycle counter
package dbg_pkg;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_HALT_PEND = 2'd1,
        ST_HALTED    = 2'd2,
        ST_ACCESS    = 2'd3
    } dbg_state_e;

    localparam logic [1:0]  CAUSE_NONE   = 2'b00;
    localparam logic [1:0]  CAUSE_REQ    = 2'b01;
    localparam logic [1:0]  CAUSE_BP     = 2'b10;

    localparam logic [3:0]  DBG_PC_REG   = 4'd15;
    localparam logic [15:0] HALT_CNT_MAX = 16'hFFFF;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == HALT_CNT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/dbg_bp_match.sv
// dbg_bp_match: instruction-address breakpoint comparator.
// Only built when DBG_BREAKPOINT_EN is defined.
//   clk, Rst         - clock, async active-high reset
//   bp_en, bp_addr   - breakpoint enable and address
//   inst_addr        - address of the instruction about to be fetched
//   cpu_at_boundary  - CPU is in S0 with a fetch pending
//   in_run           - controller is in RUN
//   resume_evt       - controller is leaving HALTED for RUN this cycle
//   bp_hit           - breakpoint condition (combinational)
`ifdef DBG_BREAKPOINT_EN
module dbg_bp_match (
    input  logic       clk,
    input  logic       Rst,
    input  logic       bp_en,
    input  logic [5:0] bp_addr,
    input  logic [5:0] inst_addr,
    input  logic       cpu_at_boundary,
    input  logic       in_run,
    input  logic       resume_evt,
    output logic       bp_hit
);

    // skip_once lets the instruction we halted on execute after a resume;
    // it is consumed by the first boundary seen in RUN.
    logic skip_once;

    assign bp_hit = in_run & bp_en & cpu_at_boundary &
                    (inst_addr == bp_addr) & ~skip_once;

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            skip_once <= 1'b0;
        end else if (resume_evt) begin
            skip_once <= 1'b1;
        end else if (in_run && cpu_at_boundary) begin
            skip_once <= 1'b0;
        end
    end

endmodule
`endif

// File: rtl/dbg_halt_ctrl.sv
// dbg_halt_ctrl: stops the CPU at an instruction boundary, gives the
// register file to a host debug port for single-register reads/writes,
// and resumes on request.
//
// Optional feature: define DBG_BREAKPOINT_EN to add bp_en/bp_addr/inst_addr
// and the instruction-address breakpoint (dbg_bp_match).
//
// Ports:
//   clk, Rst                 - clock, async active-high reset
//   halt_req, resume_req     - host level requests
//   halted, halt_cause       - halt status and cause (01 host, 10 breakpoint)
//   acc_valid/acc_ready      - host access handshake
//   acc_we/acc_addr/acc_wdata- access command
//   rdata_valid, rdata       - read result pulse and data
//   acc_err                  - pulses with completion of an access to index 15
//   cpu_at_boundary          - CPU in S0 with fetch pending
//   cpu_stall                - holds CPU in S0
//   rf_sel_dbg, rf_addr, rf_wdata, rf_we, rf_rdata - register-file port
//   halt_cnt                 - saturating count of cycles in HALTED/ACCESS
//   dbg_state                - current controller state
//
// Handshake: an access transfers on a posedge where acc_valid && acc_ready
// are both high; acc_addr/acc_we/acc_wdata are captured on that edge and
// acc_valid may change freely afterwards. acc_ready is only high in HALTED.
module dbg_halt_ctrl
    import dbg_pkg::*;
(
    input  logic        clk,
    input  logic        Rst,
    input  logic        halt_req,
    input  logic        resume_req,
    output logic        halted,
    output logic [1:0]  halt_cause,
    input  logic        acc_valid,
    output logic        acc_ready,
    input  logic        acc_we,
    input  logic [3:0]  acc_addr,
    input  logic [31:0] acc_wdata,
    output logic        rdata_valid,
    output logic [31:0] rdata,
    output logic        acc_err,
    input  logic        cpu_at_boundary,
    output logic        cpu_stall,
    output logic        rf_sel_dbg,
    output logic [3:0]  rf_addr,
    output logic [31:0] rf_wdata,
    output logic        rf_we,
    input  logic [31:0] rf_rdata,
    output logic [15:0] halt_cnt,
`ifdef DBG_BREAKPOINT_EN
    input  logic        bp_en,
    input  logic [5:0]  bp_addr,
    input  logic [5:0]  inst_addr,
`endif
    output dbg_state_e  dbg_state
);

    dbg_state_e state;
    logic       acc_we_q;
    logic       bp_hit;

`ifdef DBG_BREAKPOINT_EN
    logic resume_evt;
    assign resume_evt = (state == ST_HALTED) && !acc_valid && resume_req;

    dbg_bp_match u_bp_match (
        .clk             (clk),
        .Rst             (Rst),
        .bp_en           (bp_en),
        .bp_addr         (bp_addr),
        .inst_addr       (inst_addr),
        .cpu_at_boundary (cpu_at_boundary),
        .in_run          (state == ST_RUN),
        .resume_evt      (resume_evt),
        .bp_hit          (bp_hit)
    );
`else
    assign bp_hit = 1'b0;
`endif

    // A breakpoint hit also stalls in RUN so the CPU stays on the breakpoint
    // instruction; otherwise it would already have left S0 on the hit edge.
    assign cpu_stall = ~Rst & (halted |
                               ((state == ST_HALT_PEND) & cpu_at_boundary) |
                               bp_hit);

    assign dbg_state = state;

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state       <= ST_RUN;
            halted      <= 1'b0;
            halt_cause  <= CAUSE_NONE;
            acc_ready   <= 1'b0;
            rdata_valid <= 1'b0;
            rdata       <= '0;
            acc_err     <= 1'b0;
            rf_sel_dbg  <= 1'b0;
            rf_addr     <= '0;
            rf_wdata    <= '0;
            rf_we       <= 1'b0;
            acc_we_q    <= 1'b0;
            halt_cnt    <= '0;
        end else begin
            // single-cycle pulses
            rdata_valid <= 1'b0;
            acc_err     <= 1'b0;
            rf_we       <= 1'b0;

            case (state)
                ST_RUN: begin
                    if (halt_req) begin
                        state      <= ST_HALT_PEND;
                        halt_cause <= CAUSE_REQ;
                    end else if (bp_hit) begin
                        state      <= ST_HALT_PEND;
                        halt_cause <= CAUSE_BP;
                    end
                end

                ST_HALT_PEND: begin
                    if (cpu_at_boundary) begin
                        state      <= ST_HALTED;
                        halted     <= 1'b1;
                        rf_sel_dbg <= 1'b1;
                        acc_ready  <= 1'b1;
                        halt_cnt   <= '0;
                    end
                end

                ST_HALTED: begin
                    halt_cnt <= sat_inc16(halt_cnt);
                    if (acc_valid && acc_ready) begin
                        state     <= ST_ACCESS;
                        acc_ready <= 1'b0;
                        rf_addr   <= acc_addr;
                        rf_wdata  <= acc_wdata;
                        acc_we_q  <= acc_we;
                        rf_we     <= acc_we && (acc_addr != DBG_PC_REG);
                    end else if (resume_req) begin
                        state      <= ST_RUN;
                        halted     <= 1'b0;
                        rf_sel_dbg <= 1'b0;
                        acc_ready  <= 1'b0;
                        halt_cause <= CAUSE_NONE;
                    end
                end

                ST_ACCESS: begin
                    halt_cnt  <= sat_inc16(halt_cnt);
                    state     <= ST_HALTED;
                    acc_ready <= 1'b1;
                    if (rf_addr == DBG_PC_REG) begin
                        // index 15 reports an error for reads and writes alike
                        rdata       <= '0;
                        rdata_valid <= 1'b1;
                        acc_err     <= 1'b1;
                    end else if (!acc_we_q) begin
                        rdata       <= rf_rdata;
                        rdata_valid <= 1'b1;
                    end
                end

                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_dbg_halt_ctrl.sv
module tb_dbg_halt_ctrl;
    import dbg_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic Rst;
    always #5 clk = ~clk;

    logic        halt_req, resume_req, halted;
    logic [1:0]  halt_cause;
    logic        acc_valid, acc_ready, acc_we;
    logic [3:0]  acc_addr;
    logic [31:0] acc_wdata, rdata, rf_wdata, rf_rdata;
    logic        rdata_valid, acc_err, cpu_at_boundary, cpu_stall;
    logic        rf_sel_dbg, rf_we;
    logic [3:0]  rf_addr;
    logic [15:0] halt_cnt;
    dbg_state_e  dbg_state;

    // ---------------- CPU environment model ----------------
    logic [5:0] pc = 6'd0;
    int         phase = 0;         // 0 = in S0 with fetch pending
    assign cpu_at_boundary = (phase == 0);

`ifdef DBG_BREAKPOINT_EN
    logic       bp_en;
    logic [5:0] bp_addr;
    logic [5:0] inst_addr;
    assign inst_addr = pc;
`endif

    // register file driven through the debug port
    logic [31:0] rf_mem [16];
    assign rf_rdata = rf_mem[rf_addr];
    always @(posedge clk) if (rf_we) rf_mem[rf_addr] <= rf_wdata;

    int we_pulses = 0;
    always @(posedge clk) if (rf_we) we_pulses++;

    dbg_halt_ctrl dut (
        .clk(clk), .Rst(Rst),
        .halt_req(halt_req), .resume_req(resume_req),
        .halted(halted), .halt_cause(halt_cause),
        .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_we(acc_we),
        .acc_addr(acc_addr), .acc_wdata(acc_wdata),
        .rdata_valid(rdata_valid), .rdata(rdata), .acc_err(acc_err),
        .cpu_at_boundary(cpu_at_boundary), .cpu_stall(cpu_stall),
        .rf_sel_dbg(rf_sel_dbg), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
        .rf_we(rf_we), .rf_rdata(rf_rdata), .halt_cnt(halt_cnt),
`ifdef DBG_BREAKPOINT_EN
        .bp_en(bp_en), .bp_addr(bp_addr), .inst_addr(inst_addr),
`endif
        .dbg_state(dbg_state)
    );

    // ---------------- reference model / scoreboard ----------------
    int          m_st;              // 0 running, 1 halt pending, 2 halted
    bit          m_acc;             // access cycle in progress
    bit          m_skip;
    int          exp_cnt;
    logic [1:0]  exp_cause;
    logic [31:0] shadow [16];
    logic [31:0] exp_q [$];
    int          exp_writes = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    function automatic bit bp_hit_now();
`ifdef DBG_BREAKPOINT_EN
        return (m_st == 0) && bp_en && (phase == 0) && (pc == bp_addr) && !m_skip;
`else
        return 1'b0;
`endif
    endfunction

    // one clock: called at a negedge, returns at the next negedge
    task automatic tick();
        bit bnd, stall_s, hit;
        #1;
        bnd     = (phase == 0);
        stall_s = cpu_stall;
        hit     = bp_hit_now();
        case (m_st)
            0: begin
                if (halt_req) begin m_st = 1; exp_cause = CAUSE_REQ; end
                else if (hit) begin m_st = 1; exp_cause = CAUSE_BP; end
                if (bnd) m_skip = 1'b0;
            end
            1: if (bnd) begin m_st = 2; exp_cnt = 0; end
            default: begin
                if (exp_cnt < 65535) exp_cnt++;
                if (m_acc) m_acc = 1'b0;
                else if (acc_valid) m_acc = 1'b1;
                else if (resume_req) begin
                    m_st = 0; exp_cause = CAUSE_NONE; m_skip = 1'b1;
                end
            end
        endcase
        @(posedge clk);
        #1;
        if (phase == 0) begin
            if (!stall_s) begin
                pc++;
                phase = $urandom_range(2, 4);
            end
        end else begin
            phase--;
        end
        @(negedge clk);
        check("halted", halted, m_st == 2);
        check("cpu_stall", cpu_stall,
              (m_st == 2) || (m_st == 1 && phase == 0) || bp_hit_now());
        check("halt_cause", halt_cause, exp_cause);
        check("halt_cnt", halt_cnt, exp_cnt);
    endtask

    task automatic model_reset();
        m_st = 0; m_acc = 1'b0; m_skip = 1'b0; exp_cnt = 0; exp_cause = CAUSE_NONE;
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        halt_req = 0; resume_req = 0; acc_valid = 0; acc_we = 0;
        acc_addr = 0; acc_wdata = 0;
`ifdef DBG_BREAKPOINT_EN
        bp_en = 0; bp_addr = 0;
`endif
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_stall", cpu_stall, 0);
        Rst = 1'b0;
    endtask

    task automatic do_access(input bit we, input logic [3:0] addr, input logic [31:0] data);
        bit exp_rv;
        exp_rv = !we || (addr == DBG_PC_REG);
        check("acc_ready_pre", acc_ready, 1);
        acc_valid = 1; acc_we = we; acc_addr = addr; acc_wdata = data;
        if (exp_rv) exp_q.push_back((addr == DBG_PC_REG) ? 32'd0 : shadow[addr]);
        tick();
        acc_valid = 0; acc_we = 1'($urandom); acc_addr = 4'($urandom); acc_wdata = $urandom;
        check("rf_we", rf_we, we && (addr != DBG_PC_REG));
        check("rf_addr", rf_addr, addr);
        check("acc_ready_busy", acc_ready, 0);
        check("rdata_valid_early", rdata_valid, 0);
        if (we && addr != DBG_PC_REG) check("rf_wdata", rf_wdata, data);
        tick();
        check("acc_ready_back", acc_ready, 1);
        check("rf_we_end", rf_we, 0);
        check("rdata_valid", rdata_valid, exp_rv);
        check("acc_err", acc_err, addr == DBG_PC_REG);
        if (exp_rv && exp_q.size() > 0) check("rdata", rdata, exp_q.pop_front());
        if (we && addr != DBG_PC_REG) begin
            shadow[addr] = data;
            exp_writes++;
        end
    endtask

    task automatic halt_cpu();
        halt_req = 1;
        tick();
        if ($urandom_range(0, 1) == 1) halt_req = 0;   // dropping must not cancel
        for (int i = 0; i < 30 && m_st != 2; i++) tick();
        halt_req = 0;
        if (m_st != 2) check("halt_timeout", 0, 1);
        check("rf_sel_dbg", rf_sel_dbg, 1);
    endtask

    task automatic resume_cpu();
        resume_req = 1;
        tick();
        resume_req = 0;
        check("rf_sel_dbg_run", rf_sel_dbg, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [5:0]  pc_halt;
        logic [31:0] d;
        int          cnt_frozen, pulses0;

        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            rf_mem[i] = d;
            shadow[i] = d;
        end

        do_reset();
        check("rst_halted", halted, 0);
        check("rst_cause", halt_cause, CAUSE_NONE);
        check("rst_acc_ready", acc_ready, 0);
        check("rst_rdata_valid", rdata_valid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_acc_err", acc_err, 0);
        check("rst_rf_sel", rf_sel_dbg, 0);
        check("rst_rf_we", rf_we, 0);
        check("rst_rf_addr", rf_addr, 0);
        check("rst_rf_wdata", rf_wdata, 0);
        check("rst_halt_cnt", halt_cnt, 0);
        check("rst_state", dbg_state, ST_RUN);

`ifdef DBG_BREAKPOINT_EN
        // breakpoint: halt on the target, execute it after resume, re-halt next visit
        bp_addr = pc + 6'd3;
        bp_en = 1;
        for (int i = 0; i < 200 && m_st != 2; i++) tick();
        check("bp_halt", m_st, 2);
        check("bp_cause", halt_cause, CAUSE_BP);
        check("bp_pc", pc, bp_addr);
        resume_cpu();
        for (int i = 0; i < 50 && pc == bp_addr; i++) tick();
        check("bp_executed", pc, bp_addr + 6'd1);
        check("bp_no_rehalt", halted, 0);
        for (int i = 0; i < 800 && m_st != 2; i++) tick();
        check("bp_second_pc", pc, bp_addr);
        check("bp_second_cause", halt_cause, CAUSE_BP);
        bp_en = 0;
        resume_cpu();
`endif

        for (int round = 0; round < 4; round++) begin
            repeat ($urandom_range(3, 12)) tick();
            halt_cpu();
            pc_halt = pc;
            if (round == 0) begin
                do_access(1, 4'd3, 32'hDEADBEEF);
                do_access(0, 4'd3, 32'h0);
                pulses0 = we_pulses;
                do_access(0, 4'd15, $urandom);
                do_access(1, 4'd15, $urandom);
                check("idx15_no_write", we_pulses, pulses0);
            end
            repeat ($urandom_range(6, 10)) begin
                do_access(1'($urandom), 4'($urandom), $urandom);
                repeat ($urandom_range(0, 2)) tick();
            end
            check("no_pc_move", pc, pc_halt);
            if (round == 1) begin
                // access and resume together: access first, then resume
                resume_req = 1;
                do_access(0, 4'($urandom_range(0, 14)), 32'h0);
                check("still_halted", halted, 1);
                tick();
                resume_req = 0;
            end else begin
                resume_cpu();
            end
            cnt_frozen = exp_cnt;
            repeat (5) tick();
            check("cnt_hold", halt_cnt, cnt_frozen);
        end

        // reset in the middle of a write access
        halt_cpu();
        d = $urandom;
        acc_valid = 1; acc_we = 1; acc_addr = 4'd5; acc_wdata = ~shadow[5];
        tick();
        acc_valid = 0;
        check("mid_rf_we", rf_we, 1);
        #1 Rst = 1;
        #1;
        check("mid_rst_we", rf_we, 0);
        check("mid_rst_halted", halted, 0);
        check("mid_rst_stall", cpu_stall, 0);
        check("mid_rst_sel", rf_sel_dbg, 0);
        check("mid_rst_state", dbg_state, ST_RUN);
        model_reset();
        @(negedge clk);
        Rst = 0;
        repeat (3) tick();
        halt_cpu();
        do_access(0, 4'd5, 32'h0);   // write must have been aborted
        resume_cpu();

        check("we_pulse_total", we_pulses, exp_writes);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
